// File: rtl/id_stage_pipe.sv
// RV32I/RV32E decode stage: register file read, field decode and an ID/EX output register
// with valid/ready handshakes on both sides, load-use interlock and flush.
module id_stage_pipe #(
  parameter int NREGS          = 32,
  parameter bit BYPASS_EN      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd_s,
  input  logic [31:0] wb_rd_v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [4:0]  out_rs1_s,
  output logic [4:0]  out_rs2_s,
  output logic [31:0] out_rs1_v,
  output logic [31:0] out_rs2_v,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd_s,
  output logic        out_regf_we,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic [2:0]  out_funct3,
  output logic        out_illegal
);
  localparam int RWID = $clog2(NREGS);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] regs [NREGS];

  logic        vld_p1, we_p1, mrd_p1, mwr_p1, ill_p1;
  logic [31:0] pc_p1, inst_p1, rs1_v_p1, rs2_v_p1, imm_p1;
  logic [4:0]  rs1_s_p1, rs2_s_p1, rd_s_p1;
  logic [2:0]  f3_p1;

  function automatic logic in_range(input logic [4:0] idx);
    return (NREGS == 32) || (idx[4] == 1'b0);
  endfunction

  // x0 and out-of-range indices read as zero; bypass picks up a same-cycle write-back
  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || !in_range(idx))
      return 32'd0;
    else if (BYPASS_EN && wb_we && wb_rd_s == idx)
      return wb_rd_v;
    else
      return regs[idx[RWID-1:0]];
  endfunction

  // ---- stage 0: decode of the incoming IF/ID entry ----
  logic        use_rs1, use_rs2, use_rd, known, is_load, is_store;
  logic [31:0] imm_d;
  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    known    = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    imm_d    = 32'd0;
    case (in_inst[6:0])
      OP_LUI, OP_AUIPC: begin
        use_rd = 1'b1;
        imm_d  = {in_inst[31:12], 12'd0};
      end
      OP_JAL: begin
        use_rd = 1'b1;
        imm_d  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_JALR, OP_OPIMM, OP_LOAD: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        is_load = (in_inst[6:0] == OP_LOAD);
        imm_d   = {{21{in_inst[31]}}, in_inst[30:20]};
      end
      OP_BR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_d   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_STORE: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        is_store = 1'b1;
        imm_d    = {{21{in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
      end
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        ill_d, we_d;
  logic [31:0] rs1_v_d, rs2_v_d;
  assign rs1_d   = use_rs1 ? in_inst[19:15] : 5'd0;
  assign rs2_d   = use_rs2 ? in_inst[24:20] : 5'd0;
  assign ill_d   = !known || !in_range(rs1_d) || !in_range(rs2_d)
                   || (use_rd && !in_range(in_inst[11:7]));
  assign we_d    = use_rd && !ill_d;
  assign rd_d    = we_d ? in_inst[11:7] : 5'd0;
  assign rs1_v_d = rf_read(rs1_d);
  assign rs2_v_d = rf_read(rs2_d);

  // Interlock: the held entry is a load whose result the incoming instruction needs
  logic adv, stall, accept;
  assign adv      = !vld_p1 || out_ready;
  assign stall    = LOAD_USE_STALL && vld_p1 && mrd_p1 && (rd_s_p1 != 5'd0)
                    && ((rs1_d == rd_s_p1) || (rs2_d == rd_s_p1));
  assign in_ready = adv && !stall && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'd0;
    end else if (wb_we && wb_rd_s != 5'd0 && in_range(wb_rd_s)) begin
      regs[wb_rd_s[RWID-1:0]] <= wb_rd_v;
    end
  end

  // ---- stage 1: ID/EX register ----
  always_ff @(posedge clk) begin
    if (rst)           vld_p1 <= 1'b0;
    else if (flush)    vld_p1 <= 1'b0;
    else if (accept)   vld_p1 <= 1'b1;
    else if (adv)      vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1 <= '0; inst_p1 <= '0; rs1_s_p1 <= '0; rs2_s_p1 <= '0;
      rs1_v_p1 <= '0; rs2_v_p1 <= '0; imm_p1 <= '0; rd_s_p1 <= '0;
      we_p1 <= 1'b0; mrd_p1 <= 1'b0; mwr_p1 <= 1'b0; f3_p1 <= '0; ill_p1 <= 1'b0;
    end else if (!flush && accept) begin
      pc_p1    <= in_pc;
      inst_p1  <= in_inst;
      rs1_s_p1 <= rs1_d;
      rs2_s_p1 <= rs2_d;
      rs1_v_p1 <= rs1_v_d;
      rs2_v_p1 <= rs2_v_d;
      imm_p1   <= imm_d;
      rd_s_p1  <= rd_d;
      we_p1    <= we_d;
      mrd_p1   <= is_load && !ill_d;
      mwr_p1   <= is_store && !ill_d;
      f3_p1    <= in_inst[14:12];
      ill_p1   <= ill_d;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign out_inst    = inst_p1;
  assign out_rs1_s   = rs1_s_p1;
  assign out_rs2_s   = rs2_s_p1;
  assign out_rs1_v   = rs1_v_p1;
  assign out_rs2_v   = rs2_v_p1;
  assign out_imm     = imm_p1;
  assign out_rd_s    = rd_s_p1;
  assign out_regf_we = we_p1;
  assign out_mem_rd  = mrd_p1;
  assign out_mem_wr  = mwr_p1;
  assign out_funct3  = f3_p1;
  assign out_illegal = ill_p1;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: three instances (default, no bypass, 16 registers) share stimulus;
// expected ID/EX entries are queued per instance and popped by a monitor on each transfer.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    logic [4:0]  rd_s;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0;
  logic        wb_we = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0, in_pc = '0, wb_rd_v = '0;
  logic [4:0]  wb_rd_s = '0;

  logic        o_rdy [3], o_vld [3], o_we [3], o_mrd [3], o_mwr [3], o_ill [3];
  logic [31:0] o_pc [3], o_inst [3], o_rs1_v [3], o_rs2_v [3], o_imm [3];
  logic [4:0]  o_rs1_s [3], o_rs2_s [3], o_rd_s [3];
  logic [2:0]  o_f3 [3];

  exp_t        sbq [3][$];
  int          n_checks = 0, n_pass = 0;
  logic [31:0] pc = 32'h100;
  logic [31:0] pc_sw;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    id_stage_pipe #(
      .NREGS(k == 2 ? 16 : 32),
      .BYPASS_EN(k != 1),
      .LOAD_USE_STALL(1'b1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(o_rdy[k]), .in_inst(in_inst), .in_pc(in_pc),
      .flush(flush), .wb_we(wb_we), .wb_rd_s(wb_rd_s), .wb_rd_v(wb_rd_v),
      .out_valid(o_vld[k]), .out_ready(out_ready),
      .out_pc(o_pc[k]), .out_inst(o_inst[k]),
      .out_rs1_s(o_rs1_s[k]), .out_rs2_s(o_rs2_s[k]),
      .out_rs1_v(o_rs1_v[k]), .out_rs2_v(o_rs2_v[k]),
      .out_imm(o_imm[k]), .out_rd_s(o_rd_s[k]), .out_regf_we(o_we[k]),
      .out_mem_rd(o_mrd[k]), .out_mem_wr(o_mwr[k]),
      .out_funct3(o_f3[k]), .out_illegal(o_ill[k])
    );
  end

  function automatic exp_t mk(input logic [4:0] rs1_s, input logic [4:0] rs2_s,
                              input logic [31:0] rs1_v, input logic [31:0] rs2_v,
                              input logic [31:0] imm, input logic [4:0] rd_s, input logic we,
                              input logic mrd, input logic mwr, input logic [2:0] f3,
                              input logic ill);
    exp_t e;
    e.pc = '0; e.inst = '0; e.rs1_s = rs1_s; e.rs2_s = rs2_s; e.rs1_v = rs1_v;
    e.rs2_v = rs2_v; e.imm = imm; e.rd_s = rd_s; e.we = we; e.mrd = mrd; e.mwr = mwr;
    e.f3 = f3; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic drive(input logic [31:0] inst, input exp_t e0, input exp_t e1, input exp_t e2);
    e0.pc = pc; e0.inst = inst;
    e1.pc = pc; e1.inst = inst;
    e2.pc = pc; e2.inst = inst;
    sbq[0].push_back(e0);
    sbq[1].push_back(e1);
    sbq[2].push_back(e2);
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [31:0] inst, input exp_t e0, input exp_t e1, input exp_t e2);
    int waits;
    waits = 0;
    drive(inst, e0, e1, e2);
    @(negedge clk);
    while (!o_rdy[0] && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    if (!o_rdy[0]) begin
      n_checks++;
      $display("FAIL accept_timeout pc %h: in_ready %b required 1", pc, o_rdy[0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc += 32'd4;
  endtask

  task automatic issue3(input logic [31:0] inst, input exp_t e);
    issue(inst, e, e, e);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] v);
    wb_we = 1'b1; wb_rd_s = rd; wb_rd_v = v;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  // Monitor: an entry transfers whenever out_valid and out_ready are both high
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int k = 0; k < 3; k++) begin
        if (o_vld[k]) begin
          exp_t g, e;
          g.pc = o_pc[k]; g.inst = o_inst[k]; g.rs1_s = o_rs1_s[k]; g.rs2_s = o_rs2_s[k];
          g.rs1_v = o_rs1_v[k]; g.rs2_v = o_rs2_v[k]; g.imm = o_imm[k]; g.rd_s = o_rd_s[k];
          g.we = o_we[k]; g.mrd = o_mrd[k]; g.mwr = o_mwr[k]; g.f3 = o_f3[k]; g.ill = o_ill[k];
          n_checks++;
          if (sbq[k].size() == 0) begin
            $display("FAIL dut%0d unexpected_entry: got pc %h required no entry", k, g.pc);
          end else begin
            e = sbq[k].pop_front();
            if (g === e) n_pass++;
            else $display("FAIL dut%0d entry pc %h: got %h required %h", k, e.pc, g, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_rst", {31'd0, o_rdy[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, o_vld[0]}, 32'd0);
    chk("rst_in_ready", {31'd0, o_rdy[0]}, 32'd1);
    chk("rst_out_pc", o_pc[0], 32'd0);
    chk("rst_out_imm", o_imm[2], 32'd0);
    @(posedge clk); #1;

    // addi x6,x5,0 : x5 reads as 0 after reset
    issue3(enc_i(12'd0, 5'd5, 3'd0, 5'd6, 7'b0010011),
           mk(5'd5, 5'd0, 32'd0, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

    // addi x4,x3,1 with WB x3=0x1234 in the same cycle
    wb_we = 1'b1; wb_rd_s = 5'd3; wb_rd_v = 32'h1234;
    issue(enc_i(12'd1, 5'd3, 3'd0, 5'd4, 7'b0010011),
          mk(5'd3, 5'd0, 32'h1234, 32'd0, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
          mk(5'd3, 5'd0, 32'h0,    32'd0, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
          mk(5'd3, 5'd0, 32'h1234, 32'd0, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
    wb_we = 1'b0;
    issue3(enc_i(12'd2, 5'd3, 3'd0, 5'd4, 7'b0010011),
           mk(5'd3, 5'd0, 32'h1234, 32'd0, 32'd2, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

    // lw x7,8(x0) with WB x1=0x11, then add x8,x7,x1 -> one bubble
    wb_we = 1'b1; wb_rd_s = 5'd1; wb_rd_v = 32'h11;
    issue3(enc_i(12'd8, 5'd0, 3'd2, 5'd7, 7'b0000011),
           mk(5'd0, 5'd0, 32'd0, 32'd0, 32'd8, 5'd7, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0));
    wb_we = 1'b0;
    drive(enc_r(5'd1, 5'd7, 5'd8),
          mk(5'd7, 5'd1, 32'd0, 32'h11, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
          mk(5'd7, 5'd1, 32'd0, 32'h11, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
          mk(5'd7, 5'd1, 32'd0, 32'h11, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
    @(negedge clk);
    chk("load_use_in_ready", {31'd0, o_rdy[0]}, 32'd0);
    @(posedge clk); #1;
    chk("bubble_out_valid", {31'd0, o_vld[0]}, 32'd0);
    @(negedge clk);
    chk("after_bubble_in_ready", {31'd0, o_rdy[0]}, 32'd1);
    @(posedge clk); #1;
    chk("add_issued_out_valid", {31'd0, o_vld[0]}, 32'd1);
    in_valid = 1'b0;
    pc += 32'd4;

    // sw x1,12(x3), then execute stalls for 3 cycles while WB rewrites x3
    pc_sw = pc;
    issue3(enc_s(12'd12, 5'd1, 5'd3),
           mk(5'd3, 5'd1, 32'h1234, 32'h11, 32'd12, 5'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0));
    out_ready = 1'b0;
    wb_we = 1'b1; wb_rd_s = 5'd3; wb_rd_v = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, o_vld[0]}, 32'd1);
      chk("hold_in_ready", {31'd0, o_rdy[0]}, 32'd0);
      chk("hold_out_pc", o_pc[0], pc_sw);
      chk("hold_rs1_v", o_rs1_v[0], 32'h1234);
      @(posedge clk); #1;
      wb_we = 1'b0;
    end
    out_ready = 1'b1;

    // lui x10,0x12345 (funct3 field bits happen to be 3'b101)
    issue3(32'h12345537,
           mk(5'd0, 5'd0, 32'd0, 32'd0, 32'h12345000, 5'd10, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0));
    @(posedge clk); #1;

    // flush with a valid incoming addi; the WB of x9 still lands
    in_inst = enc_i(12'd7, 5'd0, 3'd0, 5'd11, 7'b0010011);
    in_pc = pc; in_valid = 1'b1; flush = 1'b1;
    wb_we = 1'b1; wb_rd_s = 5'd9; wb_rd_v = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; wb_we = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, o_vld[0]}, 32'd0);
    @(posedge clk); #1;
    chk("flush_dropped", {31'd0, o_vld[0]}, 32'd0);
    issue3(enc_i(12'd0, 5'd9, 3'd0, 5'd12, 7'b0010011),
           mk(5'd9, 5'd0, 32'd5, 32'd0, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

    // add x20,x1,x2: illegal only with 16 registers; WB to x17 must not alias x1
    wb(5'd2, 32'h22);
    wb(5'd17, 32'h77);
    issue(enc_r(5'd2, 5'd1, 5'd20),
          mk(5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 5'd20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
          mk(5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 5'd20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0),
          mk(5'd1, 5'd2, 32'h11, 32'h22, 32'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
    issue3(enc_i(12'd0, 5'd1, 3'd0, 5'd13, 7'b0010011),
           mk(5'd1, 5'd0, 32'h11, 32'd0, 32'd0, 5'd13, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));

    // beq x1,x2,-8 (negative B immediate), then an unknown opcode
    issue3(enc_b(13'h1FF8, 5'd2, 5'd1),
           mk(5'd1, 5'd2, 32'h11, 32'h22, 32'hFFFF_FFF8, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
    issue3(32'h0000_007F,
           mk(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("dut%0d_queue_empty", k), sbq[k].size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
